// File: rtl/i2c_slave_read_byte_if.sv
// Byte-receive handshake and pad signals between the slave top FSM/pads and the byte receiver.
`timescale 1ns/1ps
interface i2c_slave_read_byte_if;
    logic       byte_read_en;
    logic       ack_en;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic [7:0] byte_read_o;
    logic       byte_read_finish;
    logic       bus_error;

    modport master (
        output byte_read_en, ack_en, scl_i, sda_i,
        input  sda_o, byte_read_o, byte_read_finish, bus_error
    );

    modport slave (
        input  byte_read_en, ack_en, scl_i, sda_i,
        output sda_o, byte_read_o, byte_read_finish, bus_error
    );
endinterface

// File: rtl/i2c_slave_read_byte.sv
// Slave-side I2C byte receiver: samples 8 bits MSB first on SCL rise, then drives ACK/NACK
// during the 9th SCL clock. START/STOP seen mid-byte aborts and pulses bus_error.
`timescale 1ns/1ps
module i2c_slave_read_byte #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    i2c_slave_read_byte_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RECV      = 2'd1;
    localparam logic [1:0] WAIT_FALL = 2'd2;
    localparam logic [1:0] ACK_DRIVE = 2'd3;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_dly_q, sda_dly_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_stop;

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_o_q, sda_o_d;
    logic [7:0] byte_read_q, byte_read_d;
    logic       finish_q, finish_d;
    logic       bus_error_q, bus_error_d;

    // Synchronizer chain next values: stage 0 takes the pad, others shift along
    always_comb begin
        scl_sync_d    = scl_sync_q;
        sda_sync_d    = sda_sync_q;
        scl_sync_d[0] = bus.scl_i;
        sda_sync_d[0] = bus.sda_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            scl_sync_d[i] = scl_sync_q[i-1];
            sda_sync_d[i] = sda_sync_q[i-1];
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = ~scl_dly_q & scl_s;
    assign scl_fall   = scl_dly_q & ~scl_s;
    // SDA moving while SCL is stably high is a START or STOP
    assign start_stop = scl_s & scl_dly_q & (sda_s ^ sda_dly_q);

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sda_o_d     = sda_o_q;
        byte_read_d = byte_read_q;
        finish_d    = 1'b0;
        bus_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                sda_o_d = 1'b1;
                if (bus.byte_read_en) begin
                    state_d   = RECV;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end
            end
            RECV, WAIT_FALL: begin
                if (!bus.byte_read_en) begin
                    state_d = IDLE;
                    sda_o_d = 1'b1;
                end else if (start_stop) begin
                    state_d     = IDLE;
                    sda_o_d     = 1'b1;
                    bus_error_d = 1'b1;
                end else if (state_q == RECV) begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = WAIT_FALL;
                        end
                    end
                end else if (scl_fall) begin
                    sda_o_d     = ~bus.ack_en;
                    byte_read_d = shift_q;
                    state_d     = ACK_DRIVE;
                end
            end
            ACK_DRIVE: begin
                if (!bus.byte_read_en) begin
                    state_d = IDLE;
                    sda_o_d = 1'b1;
                end else if (scl_fall) begin
                    state_d  = IDLE;
                    sda_o_d  = 1'b1;
                    finish_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sda_o_d = 1'b1;
            end
        endcase
    end

    // State, datapath and synchronizer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_dly_q   <= 1'b1;
            sda_dly_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            sda_o_q     <= 1'b1;
            byte_read_q <= 8'h00;
            finish_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_dly_q   <= scl_s;
            sda_dly_q   <= sda_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sda_o_q     <= sda_o_d;
            byte_read_q <= byte_read_d;
            finish_q    <= finish_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus.sda_o            = sda_o_q;
    assign bus.byte_read_o      = byte_read_q;
    assign bus.byte_read_finish = finish_q;
    assign bus.bus_error        = bus_error_q;
endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Bench for i2c_slave_read_byte: an I2C master model on an open-drain SDA, with directed and
// randomized bytes checked against an expected-byte queue.
`timescale 1ns/1ps
module tb_i2c_slave_read_byte;
    logic clk;
    logic rst_n;
    logic m_scl;
    logic m_sda;

    i2c_slave_read_byte_if ifc ();

    i2c_slave_read_byte #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Open-drain bus: the pad is low if either side pulls low
    assign ifc.scl_i = m_scl;
    assign ifc.sda_i = m_sda & ifc.sda_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fin_cnt = 0;
    int err_cnt = 0;
    int fin_wide = 0;
    int err_wide = 0;
    int both_hi = 0;
    logic prev_fin = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] fin_q[$];
    logic [7:0] exp_q[$];
    int lo_len = 6;
    int hi_len = 6;

    // Record finish/error pulses and the byte presented with each finish
    always @(negedge clk) begin
        if (ifc.byte_read_finish) begin
            fin_cnt++;
            fin_q.push_back(ifc.byte_read_o);
        end
        if (ifc.bus_error) err_cnt++;
        if (ifc.byte_read_finish && prev_fin) fin_wide++;
        if (ifc.bus_error && prev_err) err_wide++;
        if (ifc.byte_read_finish && ifc.bus_error) both_hi++;
        prev_fin = ifc.byte_read_finish;
        prev_err = ifc.bus_error;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clock out the top nbits of b, MSB first; slave must keep SDA released throughout
    task automatic send_bits(input logic [7:0] b, input int nbits);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < nbits; i++) begin
            clks(1);
            m_sda = v[7-i];
            clks(lo_len - 1);
            m_scl = 1'b1;
            clks(hi_len);
            chk("sda_released_in_data", 32'(ifc.sda_o), 32'd1);
            m_scl = 1'b0;
        end
    endtask

    // 9th clock: master releases SDA, slave drives ACK (0) or NACK (1)
    task automatic ack_phase(input logic ack, input logic rst_mid);
        logic exp_sda;
        exp_sda = ~ack;
        clks(1);
        m_sda = 1'b1;
        clks(lo_len - 1);
        chk("ack_after_8th_fall", 32'(ifc.sda_o), 32'(exp_sda));
        m_scl = 1'b1;
        clks(hi_len);
        chk("ack_in_9th_high", 32'(ifc.sda_o), 32'(exp_sda));
        if (rst_mid) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_sda_async", 32'(ifc.sda_o), 32'd1);
            chk("rst_byte", 32'(ifc.byte_read_o), 32'h00);
            chk("rst_fin", 32'(ifc.byte_read_finish), 32'd0);
            chk("rst_err", 32'(ifc.bus_error), 32'd0);
            clks(2);
            rst_n = 1'b1;
            clks(2);
        end
        m_scl = 1'b0;
        clks(lo_len);
        chk("sda_released_after_9th", 32'(ifc.sda_o), 32'd1);
    endtask

    // Full byte with model bookkeeping and immediate result checks
    task automatic full_byte(input logic [7:0] b, input logic ack);
        int f0;
        f0 = fin_cnt;
        ifc.ack_en = ack;
        send_bits(b, 8);
        ack_phase(ack, 1'b0);
        exp_q.push_back(b);
        chk("fin_count", 32'(fin_cnt), 32'(f0 + 1));
        chk("byte_read_o", 32'(ifc.byte_read_o), 32'(b));
    endtask

    task automatic bus_start();
        m_sda = 1'b0;
        clks(5);
        m_scl = 1'b0;
        clks(5);
    endtask

    initial begin
        logic [7:0] prev_byte;
        logic [7:0] rb;
        logic       ra;
        int         f0, e0;

        rst_n = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        ifc.byte_read_en = 1'b0;
        ifc.ack_en = 1'b0;
        clks(3);
        chk("reset_sda", 32'(ifc.sda_o), 32'd1);
        chk("reset_byte", 32'(ifc.byte_read_o), 32'h00);
        chk("reset_fin", 32'(ifc.byte_read_finish), 32'd0);
        chk("reset_err", 32'(ifc.bus_error), 32'd0);
        rst_n = 1'b1;
        clks(3);
        bus_start();
        ifc.byte_read_en = 1'b1;
        clks(2);

        // ACKed byte, then NACKed byte
        lo_len = 4; hi_len = 4;
        full_byte(8'hA5, 1'b1);
        full_byte(8'h3C, 1'b0);

        // Back-to-back with enable held high
        lo_len = 4; hi_len = 4;
        full_byte(8'h13, 1'b1);
        full_byte(8'h57, 1'b1);
        full_byte(8'h9B, 1'b1);
        full_byte(8'hDF, 1'b1);

        // STOP after 3 bits of 8'hFF (4th bit low, then SDA rises with SCL high)
        prev_byte = 8'hDF;
        f0 = fin_cnt;
        e0 = err_cnt;
        lo_len = 6; hi_len = 6;
        send_bits(8'hFF, 3);
        clks(1);
        m_sda = 1'b0;
        clks(lo_len - 1);
        m_scl = 1'b1;
        clks(hi_len);
        m_sda = 1'b1;
        clks(8);
        chk("stop_err_count", 32'(err_cnt), 32'(e0 + 1));
        chk("stop_no_fin", 32'(fin_cnt), 32'(f0));
        chk("stop_byte_kept", 32'(ifc.byte_read_o), 32'(prev_byte));
        chk("stop_sda", 32'(ifc.sda_o), 32'd1);
        ifc.byte_read_en = 1'b0;
        clks(2);
        bus_start();
        ifc.byte_read_en = 1'b1;
        clks(2);
        full_byte(8'h6E, 1'b1);

        // Enable dropped after 5 bits, re-raised, then 8'h81
        f0 = fin_cnt;
        send_bits(8'hC7, 5);
        clks(2);
        ifc.byte_read_en = 1'b0;
        clks(4);
        chk("abort_no_fin", 32'(fin_cnt), 32'(f0));
        chk("abort_byte_kept", 32'(ifc.byte_read_o), 32'h6E);
        chk("abort_sda", 32'(ifc.sda_o), 32'd1);
        ifc.byte_read_en = 1'b1;
        clks(2);
        full_byte(8'h81, 1'b1);

        // Reset pulsed while the ACK is being driven, then 8'h5A
        f0 = fin_cnt;
        ifc.ack_en = 1'b1;
        send_bits(8'hE4, 8);
        ack_phase(1'b1, 1'b1);
        chk("rst_no_fin", 32'(fin_cnt), 32'(f0));
        chk("rst_byte_after", 32'(ifc.byte_read_o), 32'h00);
        full_byte(8'h5A, 1'b1);

        // Randomized bytes, ACK choice and SCL phase lengths
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            ra = 1'($urandom);
            lo_len = int'($urandom_range(4, 9));
            hi_len = int'($urandom_range(4, 9));
            full_byte(rb, ra);
        end

        // Whole-run properties
        clks(4);
        chk("fin_total", 32'(fin_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < fin_q.size(); k++) begin
            chk("fin_byte_order", 32'(fin_q[k]), 32'(exp_q[k]));
        end
        chk("err_total", 32'(err_cnt), 32'd1);
        chk("fin_one_cycle", 32'(fin_wide), 32'd0);
        chk("err_one_cycle", 32'(err_wide), 32'd0);
        chk("fin_err_exclusive", 32'(both_hi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
